// File: rtl/im_loader.sv
// im_loader: boot-time byte-stream writer for the instruction memory.
// Keeps the core in reset until a complete, checksum-verified image is written.
module im_loader #(
    parameter int ADDR_W = 10
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_load_start,
    input  logic              i_byte_valid,
    input  logic [7:0]        i_byte_data,
    output logic              o_byte_ready,
    output logic              o_IM_enable,
    output logic              o_IM_write,
    output logic              o_IM_read,
    output logic [ADDR_W-1:0] o_IM_address,
    output logic [31:0]       o_IM_in,
    output logic              o_cpu_rst,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_error
);
    typedef enum logic [2:0] {
        S_IDLE, S_LEN0, S_LEN1, S_DATA, S_WRITE, S_CSUM, S_DONE, S_ERR
    } state_t;

    state_t          r_state, w_next;
    logic [7:0]      r_xor;
    logic [ADDR_W:0] r_addr;
    logic [1:0]      r_idx;
    logic [15:0]     r_cnt;
    logic [31:0]     r_word;
    logic            w_acc;
    logic            w_start;
    logic [16:0]     w_n;
    logic [ADDR_W:0] w_addr_inc;

    assign w_acc      = i_byte_valid & o_byte_ready;
    assign w_start    = i_load_start & (r_state inside {S_IDLE, S_DONE, S_ERR});
    assign w_n        = {1'b0, i_byte_data, r_cnt[7:0]};
    assign w_addr_inc = r_addr + 1'b1;
    assign o_IM_read  = 1'b0;
    assign o_IM_address = r_addr[ADDR_W-1:0];
    assign o_IM_in    = r_word;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_DONE, S_ERR: w_next = w_start ? S_LEN0 : r_state;
            S_LEN0:  w_next = w_acc ? S_LEN1 : S_LEN0;
            S_LEN1:  w_next = !w_acc ? S_LEN1 :
                              (w_n > (17'd1 << ADDR_W)) ? S_ERR :
                              (w_n == 17'd0) ? S_CSUM : S_DATA;
            S_DATA:  w_next = (w_acc && r_idx == 2'd3) ? S_WRITE : S_DATA;
            // Address starts at 0, so addr+1 == N marks the last word.
            S_WRITE: w_next = (16'(w_addr_inc) == r_cnt) ? S_CSUM : S_DATA;
            S_CSUM:  w_next = !w_acc ? S_CSUM : (i_byte_data == r_xor) ? S_DONE : S_ERR;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_xor        <= '0;
            r_addr       <= '0;
            r_idx        <= '0;
            r_cnt        <= '0;
            r_word       <= '0;
            o_byte_ready <= 1'b0;
            o_IM_enable  <= 1'b0;
            o_IM_write   <= 1'b0;
            o_busy       <= 1'b0;
            o_done       <= 1'b0;
            o_error      <= 1'b0;
            o_cpu_rst    <= 1'b1;
        end else begin
            if (w_start) begin
                r_xor  <= '0;
                r_addr <= '0;
                r_idx  <= '0;
            end
            if (w_acc && r_state != S_CSUM) r_xor <= r_xor ^ i_byte_data;
            if (w_acc && r_state == S_LEN0) r_cnt[7:0] <= i_byte_data;
            if (w_acc && r_state == S_LEN1) r_cnt[15:8] <= i_byte_data;
            if (w_acc && r_state == S_DATA) begin
                r_word <= {r_word[23:0], i_byte_data};
                r_idx  <= r_idx + 2'd1;
            end
            if (r_state == S_WRITE) r_addr <= w_addr_inc;
            o_byte_ready <= w_next inside {S_LEN0, S_LEN1, S_DATA, S_CSUM};
            o_IM_enable  <= w_next == S_WRITE;
            o_IM_write   <= w_next == S_WRITE;
            o_busy       <= !(w_next inside {S_IDLE, S_DONE, S_ERR});
            o_done       <= w_next == S_DONE;
            o_error      <= w_next == S_ERR;
            o_cpu_rst    <= w_next != S_DONE;
        end
    end
endmodule

// File: tb/tb_im_loader.sv
// tb_im_loader: directed bench for im_loader with hand-computed expectations.
module tb_im_loader;
    localparam int AW = 10;

    logic          i_clk, i_rst, i_load_start, i_byte_valid;
    logic [7:0]    i_byte_data;
    logic          o_byte_ready, o_IM_enable, o_IM_write, o_IM_read;
    logic          o_cpu_rst, o_busy, o_done, o_error;
    logic [AW-1:0] o_IM_address;
    logic [31:0]   o_IM_in;

    int            n_chk, n_fail, cyc, wr_cnt, rdy_bad, en_bad, t_start;
    logic [31:0]   mem [0:(1<<AW)-1];
    logic [AW-1:0] wr_addr [$];
    logic [7:0]    stream [$];

    im_loader #(.ADDR_W(AW)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_load_start(i_load_start),
        .i_byte_valid(i_byte_valid), .i_byte_data(i_byte_data),
        .o_byte_ready(o_byte_ready), .o_IM_enable(o_IM_enable),
        .o_IM_write(o_IM_write), .o_IM_read(o_IM_read),
        .o_IM_address(o_IM_address), .o_IM_in(o_IM_in),
        .o_cpu_rst(o_cpu_rst), .o_busy(o_busy), .o_done(o_done), .o_error(o_error)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;
    always @(posedge i_clk) cyc++;

    // Memory model: a write cycle is observed mid-cycle and lands at the next edge.
    always @(negedge i_clk) begin
        if (o_IM_write === 1'b1 || o_IM_enable === 1'b1) begin
            if (o_IM_enable !== o_IM_write) en_bad++;
            if (o_byte_ready !== 1'b0) rdy_bad++;
            mem[o_IM_address] = o_IM_in;
            wr_addr.push_back(o_IM_address);
            wr_cnt++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic clr_log();
        wr_cnt = 0;
        wr_addr.delete();
        for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int t;
        t = 0;
        i_byte_valid = 1'b1;
        i_byte_data  = b;
        while (o_byte_ready !== 1'b1 && t < 20) begin
            @(negedge i_clk);
            t++;
        end
        if (t >= 20) chk("ready_timeout", 32'(t), 32'd0);
        @(negedge i_clk);
        i_byte_valid = 1'b0;
    endtask

    task automatic run_load(input int gap);
        i_load_start = 1'b1;
        t_start = cyc;
        @(negedge i_clk);
        i_load_start = 1'b0;
        foreach (stream[i]) begin
            i_byte_valid = 1'b0;
            if (gap > 0) repeat ($urandom_range(gap)) @(negedge i_clk);
            send_byte(stream[i]);
        end
        i_byte_valid = 1'b0;
    endtask

    task automatic nominal(input logic [7:0] csum);
        stream = '{8'h03, 8'h00, 8'h12, 8'h34, 8'h56, 8'h78, 8'hDE, 8'hAD,
                   8'hBE, 8'hEF, 8'h00, 8'h00, 8'h00, 8'h01, csum};
    endtask

    task automatic chk_mem3(input string tag);
        chk({tag, "_wr_cnt"}, 32'(wr_cnt), 32'd3);
        chk({tag, "_m0"}, mem[0], 32'h12345678);
        chk({tag, "_m1"}, mem[1], 32'hDEADBEEF);
        chk({tag, "_m2"}, mem[2], 32'h00000001);
        chk({tag, "_addrs"}, {2'b0, wr_addr[0], wr_addr[1], wr_addr[2]}, {2'b0, 10'd0, 10'd1, 10'd2});
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_flags"}, {24'b0, o_byte_ready, o_IM_enable, o_IM_write, o_IM_read,
                              o_busy, o_done, o_error, o_cpu_rst}, 32'h01);
        chk({tag, "_addr"}, 32'(o_IM_address), 32'd0);
        chk({tag, "_in"}, o_IM_in, 32'd0);
    endtask

    initial begin
        logic [7:0]  cs;
        logic [15:0] w;
        int          bad, z;
        n_chk = 0; n_fail = 0; cyc = 0; rdy_bad = 0; en_bad = 0;
        i_rst = 1'b0; i_load_start = 1'b0; i_byte_valid = 1'b0; i_byte_data = '0;
        clr_log();

        repeat (3) begin
            i_load_start = 1'($urandom);
            i_byte_valid = 1'($urandom);
            i_byte_data  = 8'($urandom);
            @(negedge i_clk);
        end
        chk_reset("reset");
        i_load_start = 1'b0; i_byte_valid = 1'b0; i_rst = 1'b1;
        repeat (5) @(negedge i_clk);
        chk_reset("idle_after_rst");

        nominal(8'h28);
        run_load(0);
        chk("nom_latency", 32'(cyc - t_start), 32'd19);
        chk("nom_done", {31'b0, o_done}, 32'd1);
        chk("nom_cpu_rst", {31'b0, o_cpu_rst}, 32'd0);
        chk("nom_err_busy", {30'b0, o_error, o_busy}, 32'd0);
        chk_mem3("nom");

        clr_log();
        nominal(8'h29);
        run_load(0);
        chk("bad_cs_flags", {29'b0, o_error, o_done, o_cpu_rst}, 32'b101);
        chk_mem3("bad_cs");

        clr_log();
        stream = '{8'h01, 8'h04};
        run_load(0);
        chk("n1025_flags", {28'b0, o_error, o_done, o_cpu_rst, o_busy}, 32'b1010);
        chk("n1025_ready", {31'b0, o_byte_ready}, 32'd0);
        repeat (3) @(negedge i_clk);
        chk("n1025_writes", 32'(wr_cnt), 32'd0);

        clr_log();
        stream = '{8'h00, 8'h00, 8'h00};
        run_load(0);
        chk("n0_flags", {28'b0, o_error, o_done, o_cpu_rst, o_busy}, 32'b0100);
        chk("n0_writes", 32'(wr_cnt), 32'd0);

        clr_log();
        stream = '{8'h00, 8'h04};
        cs = 8'h04;
        for (int i = 0; i < 1024; i++) begin
            w = 16'(i);
            stream.push_back(8'hA5); stream.push_back(8'h00);
            stream.push_back(w[15:8]); stream.push_back(w[7:0]);
            cs = cs ^ 8'hA5 ^ w[15:8] ^ w[7:0];
        end
        stream.push_back(cs);
        run_load(0);
        chk("n1024_done", {30'b0, o_done, o_error}, 32'b10);
        chk("n1024_writes", 32'(wr_cnt), 32'd1024);
        chk("n1024_last_addr", 32'(wr_addr[wr_addr.size() - 1]), 32'd1023);
        chk("n1024_m0", mem[0], 32'hA5000000);
        chk("n1024_m1023", mem[1023], 32'hA50003FF);
        bad = 0; z = 0;
        foreach (wr_addr[i]) begin
            if (32'(wr_addr[i]) != i) bad++;
            if (wr_addr[i] == '0) z++;
        end
        chk("n1024_seq", 32'(bad), 32'd0);
        chk("n1024_addr0_once", 32'(z), 32'd1);

        clr_log();
        nominal(8'h28);
        run_load(3);
        chk("gap_done", {30'b0, o_done, o_error}, 32'b10);
        chk_mem3("gap");

        clr_log();
        stream = '{8'h03, 8'h00, 8'h12, 8'h34, 8'h56, 8'h78, 8'hDE, 8'hAD};
        run_load(0);
        chk("mid_busy", {31'b0, o_busy}, 32'd1);
        i_rst = 1'b0;
        repeat (2) @(negedge i_clk);
        i_rst = 1'b1;
        chk_reset("mid_rst");
        repeat (3) @(negedge i_clk);
        chk("mid_writes", 32'(wr_cnt), 32'd1);
        chk("mid_addr0", {22'b0, wr_addr[0]}, 32'd0);
        chk("mid_idle", {30'b0, o_busy, o_byte_ready}, 32'd0);

        clr_log();
        nominal(8'h28);
        run_load(0);
        chk("reload_done", {29'b0, o_done, o_error, o_cpu_rst}, 32'b100);
        chk_mem3("reload");

        chk("ready_low_in_write", 32'(rdy_bad), 32'd0);
        chk("enable_eq_write", 32'(en_bad), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
